input_map: RTL and testbench



---
 rtl/input_map.sv | 150 +++++++++++++++
 tb/tb_input_map.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_map.sv
// input_map: memory-mapped input peripheral on the CPU data bus.
//
// Switches and push-buttons are synchronized through two flops and then
// debounced per bit. The stable levels are readable. A button press
// (stable 0->1) sets a sticky event bit that is cleared by writing 1. The
// events are ANDed with an interrupt mask to produce a registered irq.
//
// Register map (full 32-bit address compare, zero-extended data):
//   0x0  debounced switches          read-only
//   0x4  debounced buttons           read-only
//   0x8  button press events         sticky, write-1-to-clear
//   0xC  irq mask                    read/write
//   Any other address reads 0, and writes to it are ignored.
//
// Ports:
//   clk                 system clock, posedge
//   rst_n               asynchronous active-low reset
//   input_address       byte address of the access
//   input_in            write data
//   input_size          access size, accepted but ignored
//   input_write_enable  write strobe, sampled on posedge clk
//   input_out           combinational read data
//   switches            raw asynchronous switch pins
//   buttons             raw asynchronous button pins
//   irq                 registered interrupt request
module input_map #(
  parameter int NUM_SWITCHES      = 8,
  parameter int NUM_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             input_address,
  input  logic [31:0]             input_in,
  input  logic [1:0]              input_size,
  input  logic                    input_write_enable,
  output logic [31:0]             input_out,
  input  logic [NUM_SWITCHES-1:0] switches,
  input  logic [NUM_BUTTONS-1:0]  buttons,
  output logic                    irq
);

  // Switches occupy the low bits of the combined vector, buttons the high bits.
  localparam int NB = NUM_SWITCHES + NUM_BUTTONS;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] ADDR_SW   = 32'h0000_0000;
  localparam logic [31:0] ADDR_BTN  = 32'h0000_0004;
  localparam logic [31:0] ADDR_EVT  = 32'h0000_0008;
  localparam logic [31:0] ADDR_MASK = 32'h0000_000C;

  logic [NUM_BUTTONS-1:0]  btn_lvl_s;
  logic [NB-1:0]           raw_s;
  logic [NB-1:0]           sync1_q, sync2_q;
  logic [NB-1:0]           stable_q, stable_d;
  logic [NB-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0]  events_q, events_d;
  logic [NUM_BUTTONS-1:0]  mask_q, mask_d;
  logic [NUM_BUTTONS-1:0]  rise_s, clr_s;
  logic                    irq_q, irq_d;
  logic                    wr_evt_s, wr_mask_s;
  logic [31:0]             rd_data_s;
  logic                    unused_s;

  // Buttons are normalised so that "pressed" is 1 before synchronization;
  // this makes the reset value 0 mean "not pressed".
  assign btn_lvl_s = (BUTTON_ACTIVE_LOW != 0) ? ~buttons : buttons;
  assign raw_s     = {btn_lvl_s, switches};

  // Bus size and the unused upper write-data bits carry no function here.
  assign unused_s = ^{input_size, input_in};

  assign wr_evt_s  = input_write_enable && (input_address == ADDR_EVT);
  assign wr_mask_s = input_write_enable && (input_address == ADDR_MASK);

  // Per-bit debounce: count consecutive cycles the synced level disagrees
  // with the stable level; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Press events, W1C clearing (a same-cycle new press wins), mask and irq.
  always_comb begin
    rise_s   = stable_d[NB-1:NUM_SWITCHES] & ~stable_q[NB-1:NUM_SWITCHES];
    clr_s    = '0;
    mask_d   = mask_q;
    if (wr_evt_s) begin
      clr_s = input_in[NUM_BUTTONS-1:0];
    end else begin
      clr_s = '0;
    end
    if (wr_mask_s) begin
      mask_d = input_in[NUM_BUTTONS-1:0];
    end else begin
      mask_d = mask_q;
    end
    events_d = (events_q & ~clr_s) | rise_s;
    irq_d    = |(events_q & mask_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      events_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= raw_s;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      events_q <= events_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
    end
  end

  // Zero-latency read mux; reads have no side effects.
  always_comb begin
    rd_data_s = '0;
    case (input_address)
      ADDR_SW:   rd_data_s[NUM_SWITCHES-1:0] = stable_q[NUM_SWITCHES-1:0];
      ADDR_BTN:  rd_data_s[NUM_BUTTONS-1:0]  = stable_q[NB-1:NUM_SWITCHES];
      ADDR_EVT:  rd_data_s[NUM_BUTTONS-1:0]  = events_q;
      ADDR_MASK: rd_data_s[NUM_BUTTONS-1:0]  = mask_q;
      default:   rd_data_s = '0;
    endcase
  end

  assign input_out = rd_data_s;
  assign irq       = irq_q;

endmodule

// File: tb/tb_input_map.sv
// Self-checking bench for input_map with DEBOUNCE_CYCLES=4 and active-low
// buttons. A reference model predicts every register and irq each cycle:
// a stable level flips once the synchronized input has disagreed with it
// for the last DB consecutive edges (the synchronized input at an edge is
// the raw level sampled two edges earlier).
module tb_input_map;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] input_address = 32'h0;
  logic [31:0] input_in = 32'h0;
  logic [1:0]  input_size = 2'b10;
  logic        input_write_enable = 1'b0;
  logic [31:0] input_out;
  logic [7:0]  switches = 8'h00;
  logic [3:0]  buttons = 4'hF;
  logic        irq;

  int total = 0;
  int bad = 0;

  input_map #(
    .NUM_SWITCHES(8), .NUM_BUTTONS(4), .DEBOUNCE_CYCLES(DB), .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .input_address(input_address), .input_in(input_in),
    .input_size(input_size), .input_write_enable(input_write_enable),
    .input_out(input_out), .switches(switches), .buttons(buttons), .irq(irq)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  logic [11:0] rq[$];
  logic [11:0] dq[$];
  logic [11:0] m_stable = 12'h0;
  logic [3:0]  m_ev = 4'h0;
  logic [3:0]  m_mask = 4'h0;
  logic        m_irq = 1'b0;
  logic [11:0] m_d, m_ns;
  logic [3:0]  m_rise, m_clr;
  logic        m_all;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.delete();
      dq.delete();
      m_stable = 12'h0;
      m_ev     = 4'h0;
      m_mask   = 4'h0;
      m_irq    = 1'b0;
    end else begin
      m_d = (rq.size() >= 2) ? rq[rq.size()-2] : 12'h0;
      rq.push_back({~buttons, switches});
      if (rq.size() > 3) void'(rq.pop_front());
      dq.push_back(m_d);
      if (dq.size() > DB) void'(dq.pop_front());
      m_ns = m_stable;
      if (dq.size() == DB) begin
        for (int b = 0; b < 12; b++) begin
          m_all = 1'b1;
          for (int k = 0; k < DB; k++)
            if (dq[k][b] == m_stable[b]) m_all = 1'b0;
          if (m_all) m_ns[b] = ~m_stable[b];
        end
      end
      m_rise = m_ns[11:8] & ~m_stable[11:8];
      m_clr  = (input_write_enable && input_address == 32'h8) ? input_in[3:0] : 4'h0;
      m_irq  = |(m_ev & m_mask);
      m_ev   = (m_ev & ~m_clr) | m_rise;
      if (input_write_enable && input_address == 32'hC) m_mask = input_in[3:0];
      m_stable = m_ns;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      32'h0:   return {24'h0, m_stable[7:0]};
      32'h4:   return {28'h0, m_stable[11:8]};
      32'h8:   return {28'h0, m_ev};
      32'hC:   return {28'h0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    input_address = a;
    #1;
    v = input_out;
  endtask

  task automatic check_all();
    logic [31:0] addrs [6];
    logic [31:0] v;
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h108};
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], v);
      check_val($sformatf("rd_%0h", addrs[i]), v, model_read(addrs[i]));
    end
    check_val("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  // Advance one edge, drop any write strobe, then check at the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 input_write_enable = 1'b0;
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    input_address      = a;
    input_in           = d;
    input_write_enable = 1'b1;
    tick();
  endtask

  logic [31:0] v;

  initial begin
    // Reset state
    tick(2);
    rst_n = 1'b1;
    rd(32'h0, v);  check_val("rst_sw", v, 32'h0);
    rd(32'h4, v);  check_val("rst_btn", v, 32'h0);
    rd(32'h8, v);  check_val("rst_evt", v, 32'h0);
    rd(32'hC, v);  check_val("rst_mask", v, 32'h0);
    rd(32'h10, v); check_val("rst_unmapped", v, 32'h0);
    check_val("rst_irq", {31'h0, irq}, 32'h0);
    tick(8);

    // Switch latency: visible after exactly 2+DB edges
    switches = 8'h08;
    tick(5);
    rd(32'h0, v); check_val("sw_edge5", v, 32'h0);
    tick();
    rd(32'h0, v); check_val("sw_edge6", v, 32'h8);
    rd(32'h8, v); check_val("sw_no_evt", v, 32'h0);
    check_val("sw_no_irq", {31'h0, irq}, 32'h0);

    // Button glitch shorter than the debounce window
    buttons = 4'b1101;
    tick(3);
    buttons = 4'b1111;
    tick(6);
    rd(32'h4, v); check_val("glitch_btn", v, 32'h0);
    rd(32'h8, v); check_val("glitch_evt", v, 32'h0);

    // Press, release, W1C
    buttons = 4'b1101;
    tick(6);
    rd(32'h4, v); check_val("press_btn", v, 32'h2);
    rd(32'h8, v); check_val("press_evt", v, 32'h2);
    buttons = 4'b1111;
    tick(6);
    rd(32'h4, v); check_val("rel_btn", v, 32'h0);
    rd(32'h8, v); check_val("rel_evt", v, 32'h2);
    wr(32'h8, 32'h4);
    rd(32'h8, v); check_val("w1c_other", v, 32'h2);
    wr(32'h8, 32'h2);
    rd(32'h8, v); check_val("w1c_clear", v, 32'h0);

    // Mask and irq timing, then set-beats-clear
    wr(32'hC, 32'hFFFF_FFF2);
    rd(32'hC, v); check_val("mask_rd", v, 32'h2);
    buttons = 4'b1101;
    tick(6);
    rd(32'h8, v); check_val("irq_evt", v, 32'h2);
    check_val("irq_lag", {31'h0, irq}, 32'h0);
    tick();
    check_val("irq_set", {31'h0, irq}, 32'h1);
    buttons = 4'b1111;
    tick(6);
    check_val("irq_level", {31'h0, irq}, 32'h1);
    buttons = 4'b1101;
    tick(5);
    wr(32'h8, 32'h2);
    rd(32'h8, v); check_val("set_wins", v, 32'h2);
    check_val("set_wins_irq", {31'h0, irq}, 32'h1);

    // Reset in the middle of a debounce with the button still held
    buttons = 4'b1111;
    tick(6);
    wr(32'h8, 32'hF);
    tick(2);
    buttons = 4'b1101;
    tick(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(5);
    rd(32'h4, v); check_val("rstmid_edge5", v, 32'h0);
    tick();
    rd(32'h4, v); check_val("rstmid_btn", v, 32'h2);
    rd(32'h8, v); check_val("rstmid_evt", v, 32'h2);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) switches[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) buttons[$urandom_range(0, 3)] ^= 1'b1;
      input_size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          0: input_address = 32'h0;
          1: input_address = 32'h4;
          2, 3: input_address = 32'h8;
          4: input_address = 32'hC;
          5: input_address = 32'h10;
          default: input_address = 32'h108;
        endcase
        input_in           = $urandom;
        input_write_enable = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
